// File: rtl/register_file_param.sv
// Parametrised decode-stage register file: two async read ports, one masked
// synchronous write port, a post-reset clear sweep, optional zero reg and bypass.
module register_file_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] write_mask,
  input  logic [ADDR_WIDTH-1:0]   write_reg,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [ADDR_WIDTH-1:0]   read_reg1,
  input  logic [ADDR_WIDTH-1:0]   read_reg2,
  output logic [DATA_WIDTH-1:0]   read_data1,
  output logic [DATA_WIDTH-1:0]   read_data2,
  output logic                    busy,
  output logic                    drop
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   ptr, ptr_nxt;
  logic                    busy_nxt;
  logic                    drop_nxt;
  logic [DATA_WIDTH-1:0]   regs [DEPTH];

  logic                    zero_wr_c;
  logic                    write_ok_c;
  logic [DATA_WIDTH-1:0]   wr_merged_c;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [NUM_BYTES-1:0]  mask
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (mask[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // State register; reset restarts the sweep without touching the array.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      busy  <= busy_nxt;
      drop  <= drop_nxt;
    end
  end

  // Next-state: sweep one entry per edge, leave CLEAR after the last entry.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    busy_nxt  = 1'b0;
    drop_nxt  = 1'b0;
    case (state)
      CLEAR: begin
        ptr_nxt  = ADDR_WIDTH'(ptr + 1'b1);
        drop_nxt = we;
        if (ptr == ADDR_WIDTH'(DEPTH - 1)) begin
          state_nxt = READY;
          busy_nxt  = 1'b0;
        end else begin
          busy_nxt  = 1'b1;
        end
      end
      READY: begin
        busy_nxt = 1'b0;
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
        busy_nxt  = 1'b1;
      end
    endcase
  end

  always_comb begin
    zero_wr_c   = ZERO_REG && (write_reg == '0);
    write_ok_c  = (state == READY) && we && !zero_wr_c;
    wr_merged_c = merge_bytes(regs[write_reg], write_data, write_mask);
  end

  // Array update: clear sweep in CLEAR, masked write-back in READY.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        regs[ptr] <= '0;
      end else if (write_ok_c) begin
        regs[write_reg] <= wr_merged_c;
      end
    end
  end

  // Read ports resolve busy, zero register, bypass, then stored value.
  always_comb begin
    read_data1 = regs[read_reg1];
    if (busy || (ZERO_REG && (read_reg1 == '0))) begin
      read_data1 = '0;
    end else if (BYPASS && write_ok_c && (write_reg == read_reg1)) begin
      read_data1 = wr_merged_c;
    end
  end

  always_comb begin
    read_data2 = regs[read_reg2];
    if (busy || (ZERO_REG && (read_reg2 == '0))) begin
      read_data2 = '0;
    end else if (BYPASS && write_ok_c && (write_reg == read_reg2)) begin
      read_data2 = wr_merged_c;
    end
  end

endmodule
